aes_dec_iter: RTL and testbench
===============================

AES_DEC_ITER -- requirements
Module: aes_dec_iter

Interface
REQ-001 clk  input  1  single clock; all state updates on its rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 in_valid  input  1  ct_in/key_in presented.
REQ-004 in_ready  output  1  block can accept a new job.
REQ-005 ct_in  input  128  ciphertext block, FIPS-197 byte order (byte 0 = bits 127:120).
REQ-006 key_in  input  128  AES-128 cipher key (round-0 key), same byte order.
REQ-007 out_valid  output  1  pt_out holds a finished plaintext.
REQ-008 out_ready  input  1  consumer accepts pt_out.
REQ-009 pt_out  output  128  decrypted plaintext.

Function
REQ-010 FSM states SHALL be IDLE, KEYEXP, ROUND and DONE.
REQ-011 in_ready SHALL be 1 only in IDLE; a job is accepted on an edge where in_valid && in_ready.
REQ-012 On accept, the block SHALL register ct_in and key_in, clear the round counter, and enter KEYEXP.
REQ-013 KEYEXP SHALL run the forward key schedule, one round key per cycle, for exactly 10 cycles (rk1..rk10).
REQ-014 On the 10th KEYEXP edge, the block SHALL load state <= ct ^ rk10 and enter ROUND.
REQ-015 ROUND SHALL take 10 cycles; each cycle derives rk(i-1) from rk(i) with the inverse key schedule: w'[j]=w[j]^w[j-1] for j=3..1; w'[0]=w[0]^SubWord(RotWord(w'[3]))^rcon[i].
REQ-016 Rounds 9..1 SHALL apply InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns; round 0 SHALL omit InvMixColumns.
REQ-017 After the 10th ROUND edge, pt_out SHALL hold the plaintext and the block SHALL enter DONE with out_valid=1.
REQ-018 Latency SHALL be exactly 20 cycles from the accept edge to the first cycle with out_valid=1.
REQ-019 In DONE, pt_out and out_valid SHALL stay stable until out_ready=1; the block then returns to IDLE.
REQ-020 A new job SHALL NOT be accepted on the same edge as the output handshake; in_ready rises the cycle after.
REQ-021 ct_in/key_in changes after accept SHALL have no effect on the running job.
REQ-022 out_ready SHALL be ignored outside DONE.

Reset
REQ-023 While rst_n=0: FSM=IDLE, in_ready=1, out_valid=0, pt_out=0, counter=0, internal key/state registers=0.
REQ-024 Reset asserted mid-job SHALL abort the job immediately, with no partial output.
REQ-025 Reset SHALL clear the key cache (REQ-026) to invalid.

Configuration
REQ-026 With AES_DEC_KEY_CACHE_EN defined, the block SHALL store key_in and rk10 at the end of KEYEXP and set a cache-valid flag.
REQ-027 With AES_DEC_KEY_CACHE_EN, on accept with cache valid and key_in equal to the cached key, the block SHALL load state <= ct_in ^ cached rk10, skip KEYEXP and enter ROUND; latency SHALL then be 10 cycles.
REQ-028 Without AES_DEC_KEY_CACHE_EN, no cache registers SHALL exist and latency SHALL always be 20 cycles.

Structure
REQ-029 Package aes_pkg SHALL hold the FSM state enum, the S-box and inverse S-box functions, the rcon table, and the constants NR=10 and BLOCK_W=128.
REQ-030 Sub-module aes_inv_round (combinational) SHALL take state, round key and a last-round flag and return the next state; the inverse key step is a function in aes_pkg.
REQ-031 The forward key step SHALL reuse the existing KeyExpansion round logic functionally (one round per cycle, rcon indexed by counter).

Verification
REQ-032 FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> pt 3243f6a8885a308d313198a2e0370734 with out_valid first high 20 cycles after accept.
REQ-033 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> pt 00112233445566778899aabbccddeeff.
REQ-034 Backpressure: out_ready held 0 for 7 cycles -> pt_out stable, in_ready=0 throughout; out_ready=1 -> IDLE on the next cycle.
REQ-035 Reset asserted at cycle 12 of a job -> out_valid=0, pt_out=0 at once; a following C.1 job completes correctly.
REQ-036 Cache enabled: two back-to-back C.1-key jobs -> second has latency 10; a changed key -> latency 20; after reset -> latency 20.
REQ-037 Inputs toggled randomly during a job -> result unchanged.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared definitions for the iterative AES-128 decryptor.
//   - state_e        : controller states (IDLE, KEYEXP, ROUND, DONE)
//   - NR, BLOCK_W    : round count and block width
//   - sbox/inv_sbox  : byte substitutions, computed algebraically (GF(2^8)
//                      inverse plus affine map) rather than stored as tables
//   - rcon           : round constant table, indexed 1..10
//   - key_step_fwd   : one KeyExpansion round, rk(i-1) -> rk(i)
//   - key_step_inv   : inverse key step, rk(i) -> rk(i-1)
package aes_pkg;

  localparam int NR      = 10;
  localparam int BLOCK_W = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KEYEXP = 2'd1,
    ROUND  = 2'd2,
    DONE   = 2'd3
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8) and conveniently maps 0 to 0.
  // 254 = 2+4+...+128, so accumulate the successive squares a^(2^i), i=1..7.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] a;
    a = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(a);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [BLOCK_W-1:0] key_step_fwd(input logic [BLOCK_W-1:0] rk,
                                                      input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = rk[127:96] ^ sub_word(rot_word(rk[31:0])) ^ {rc, 24'h000000};
    w1 = rk[95:64] ^ w0;
    w2 = rk[63:32] ^ w1;
    w3 = rk[31:0]  ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Undo one forward step: the last three words unwind by XOR with their
  // left neighbour, after which w'[3] is known and w'[0] can be recovered.
  function automatic logic [BLOCK_W-1:0] key_step_inv(input logic [BLOCK_W-1:0] rk,
                                                      input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = rk[31:0]  ^ rk[63:32];
    w2 = rk[63:32] ^ rk[95:64];
    w1 = rk[95:64] ^ rk[127:96];
    w0 = rk[127:96] ^ sub_word(rot_word(w3)) ^ {rc, 24'h000000};
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_dec_iter_if.sv
// aes_dec_iter_if: job handshake bundle for aes_dec_iter.
//   in_valid/in_ready  : job request with ct_in (ciphertext) and key_in
//   out_valid/out_ready: result handshake carrying pt_out (plaintext)
// modport master = job producer/result consumer, slave = the decryptor.
interface aes_dec_iter_if;
  import aes_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [BLOCK_W-1:0] ct_in;
  logic [BLOCK_W-1:0] key_in;
  logic               out_valid;
  logic               out_ready;
  logic [BLOCK_W-1:0] pt_out;

  modport master (
    output in_valid, ct_in, key_in, out_ready,
    input  in_ready, out_valid, pt_out
  );

  modport slave (
    input  in_valid, ct_in, key_in, out_ready,
    output in_ready, out_valid, pt_out
  );

endinterface

// File: rtl/aes_inv_round.sv
// aes_inv_round: one combinational AES inverse round.
//   state_i : current 128-bit state (byte 0 = bits 127:120, column-major)
//   rk_i    : round key for this round
//   last_i  : final round, skips InvMixColumns
//   state_o : InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] state_i,
  input  logic [BLOCK_W-1:0] rk_i,
  input  logic               last_i,
  output logic [BLOCK_W-1:0] state_o
);

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  logic [7:0]  in_b  [16];
  logic [7:0]  shr_b [16];
  logic [7:0]  sub_b [16];
  logic [31:0] col;

  // Byte index k = 4*column + row. InvShiftRows rotates row r right by r,
  // so the byte at column c lands in column (c + r) mod 4.
  always_comb begin
    in_b    = '{default: 8'h00};
    shr_b   = '{default: 8'h00};
    sub_b   = '{default: 8'h00};
    col     = '0;
    state_o = '0;
    for (int k = 0; k < 16; k++) begin
      in_b[k] = state_i[BLOCK_W-1-8*k -: 8];
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shr_b[4*((c+r)%4)+r] = in_b[4*c+r];
      end
    end
    for (int k = 0; k < 16; k++) begin
      sub_b[k] = inv_sbox(shr_b[k]) ^ rk_i[BLOCK_W-1-8*k -: 8];
    end
    for (int c = 0; c < 4; c++) begin
      col = {sub_b[4*c], sub_b[4*c+1], sub_b[4*c+2], sub_b[4*c+3]};
      state_o[BLOCK_W-1-32*c -: 32] = last_i ? col : inv_mix_col(col);
    end
  end

endmodule

// File: rtl/aes_dec_iter.sv
// aes_dec_iter: iterative AES-128 decryptor, one round per clock.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : aes_dec_iter_if.slave (in_valid/in_ready/ct_in/key_in,
//                out_valid/out_ready/pt_out)
// A job runs the forward key schedule for 10 cycles to reach rk10, then
// decrypts for 10 cycles while walking the key schedule backwards, so no
// round-key storage is needed. Result appears 20 cycles after accept.
// Optional feature macro AES_DEC_KEY_CACHE_EN: remembers the last key and
// its rk10; a job with the same key skips the forward schedule (10 cycles).
module aes_dec_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  aes_dec_iter_if.slave bus
);

  localparam logic [3:0] LAST_CNT = 4'(NR - 1);

  state_e             fsm_q, fsm_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [BLOCK_W-1:0] ct_q,  ct_d;
  logic [BLOCK_W-1:0] rk_q,  rk_d;
  logic [BLOCK_W-1:0] st_q,  st_d;
  logic [BLOCK_W-1:0] pt_q,  pt_d;

  logic [BLOCK_W-1:0] rk_fwd;
  logic [BLOCK_W-1:0] rk_inv;
  logic [BLOCK_W-1:0] round_out;
  logic               last_round;

`ifdef AES_DEC_KEY_CACHE_EN
  logic [BLOCK_W-1:0] cache_key_q, cache_key_d;
  logic [BLOCK_W-1:0] cache_rk_q,  cache_rk_d;
  logic               cache_vld_q, cache_vld_d;
  logic               cache_hit;
  assign cache_hit = cache_vld_q && (bus.key_in == cache_key_q);
`endif

  // In KEYEXP rk_q holds rk(cnt); in ROUND it holds rk(10-cnt), and the
  // round applied is 9-cnt using the key derived this cycle.
  assign rk_fwd     = key_step_fwd(rk_q, rcon(cnt_q + 4'd1));
  assign rk_inv     = key_step_inv(rk_q, rcon(4'(NR) - cnt_q));
  assign last_round = (cnt_q == LAST_CNT);

  aes_inv_round u_round (
    .state_i (st_q),
    .rk_i    (rk_inv),
    .last_i  (last_round),
    .state_o (round_out)
  );

  assign bus.in_ready  = (fsm_q == IDLE);
  assign bus.out_valid = (fsm_q == DONE);
  assign bus.pt_out    = pt_q;

  always_comb begin
    fsm_d = fsm_q;
    cnt_d = cnt_q;
    ct_d  = ct_q;
    rk_d  = rk_q;
    st_d  = st_q;
    pt_d  = pt_q;
`ifdef AES_DEC_KEY_CACHE_EN
    cache_key_d = cache_key_q;
    cache_rk_d  = cache_rk_q;
    cache_vld_d = cache_vld_q;
`endif
    case (fsm_q)
      IDLE: begin
        if (bus.in_valid) begin
          ct_d  = bus.ct_in;
          rk_d  = bus.key_in;
          cnt_d = '0;
          fsm_d = KEYEXP;
`ifdef AES_DEC_KEY_CACHE_EN
          // On a miss the cache is invalidated until this key's rk10 exists.
          if (cache_hit) begin
            rk_d  = cache_rk_q;
            st_d  = bus.ct_in ^ cache_rk_q;
            fsm_d = ROUND;
          end else begin
            cache_key_d = bus.key_in;
            cache_vld_d = 1'b0;
          end
`endif
        end
      end
      KEYEXP: begin
        rk_d = rk_fwd;
        if (last_round) begin
          st_d  = ct_q ^ rk_fwd;
          cnt_d = '0;
          fsm_d = ROUND;
`ifdef AES_DEC_KEY_CACHE_EN
          cache_rk_d  = rk_fwd;
          cache_vld_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ROUND: begin
        rk_d = rk_inv;
        st_d = round_out;
        if (last_round) begin
          pt_d  = round_out;
          cnt_d = '0;
          fsm_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= IDLE;
      cnt_q <= '0;
      ct_q  <= '0;
      rk_q  <= '0;
      st_q  <= '0;
      pt_q  <= '0;
    end else begin
      fsm_q <= fsm_d;
      cnt_q <= cnt_d;
      ct_q  <= ct_d;
      rk_q  <= rk_d;
      st_q  <= st_d;
      pt_q  <= pt_d;
    end
  end

`ifdef AES_DEC_KEY_CACHE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_key_q <= '0;
      cache_rk_q  <= '0;
      cache_vld_q <= 1'b0;
    end else begin
      cache_key_q <= cache_key_d;
      cache_rk_q  <= cache_rk_d;
      cache_vld_q <= cache_vld_d;
    end
  end
`endif

endmodule

// File: tb/tb_aes_dec_iter.sv
// tb_aes_dec_iter: self-checking bench for aes_dec_iter.
// Known-answer table plus randomized jobs compared against a reference
// AES-128 decryptor (full key expansion, table-driven S-boxes built from
// generator iteration) and a latency model of the optional key cache.
module tb_aes_dec_iter;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;

`ifdef AES_DEC_KEY_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aes_dec_iter_if bus ();

  aes_dec_iter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [7:0]   sb  [256];
  logic [7:0]   isb [256];
  bit           cacheValid;
  logic [127:0] cacheKey;

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
    bit           toggle;
  } vec_t;

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mulGf(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = xt(x);
    end
    return r;
  endfunction

  task automatic buildTables();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    for (int n = 0; n < 255; n++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'b0000};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end
    sb[0] = 8'h63;
    for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
  endtask

  function automatic logic [127:0] refDecrypt(input logic [127:0] key, input logic [127:0] ct);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int k = 0; k < 16; k++) s[k] = ct[127-8*k -: 8] ^ w[40 + k/4][31-8*(k%4) -: 8];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[4*((c+r)%4)+r] = s[4*c+r];
      for (int k = 0; k < 16; k++) t[k] = isb[t[k]] ^ w[4*rnd + k/4][31-8*(k%4) -: 8];
      for (int c = 0; c < 4; c++) begin
        if (rnd > 0) begin
          s[4*c]   = mulGf(t[4*c],8'h0e) ^ mulGf(t[4*c+1],8'h0b) ^ mulGf(t[4*c+2],8'h0d) ^ mulGf(t[4*c+3],8'h09);
          s[4*c+1] = mulGf(t[4*c],8'h09) ^ mulGf(t[4*c+1],8'h0e) ^ mulGf(t[4*c+2],8'h0b) ^ mulGf(t[4*c+3],8'h0d);
          s[4*c+2] = mulGf(t[4*c],8'h0d) ^ mulGf(t[4*c+1],8'h09) ^ mulGf(t[4*c+2],8'h0e) ^ mulGf(t[4*c+3],8'h0b);
          s[4*c+3] = mulGf(t[4*c],8'h0b) ^ mulGf(t[4*c+1],8'h0d) ^ mulGf(t[4*c+2],8'h09) ^ mulGf(t[4*c+3],8'h0e);
        end else begin
          for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
        end
      end
    end
    for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
    return res;
  endfunction

  function automatic int expLatency(input logic [127:0] key);
    return (CACHE_EN && cacheValid && key == cacheKey) ? 10 : 20;
  endfunction

  task automatic noteJob(input logic [127:0] key);
    cacheValid = 1'b1;
    cacheKey   = key;
  endtask

  // ---------------- checking / stimulus tasks ----------------
  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic startJob(input logic [127:0] key, input logic [127:0] ct);
    @(negedge clk);
    checkOutput("in_ready_before_accept", 128'(bus.in_ready), 128'd1);
    bus.in_valid = 1'b1;
    bus.ct_in    = ct;
    bus.key_in   = key;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input bit toggle, output int lat, output bit busyBad);
    lat     = 0;
    busyBad = 1'b0;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      if (bus.in_ready !== 1'b0) busyBad = 1'b1;
      if (toggle) begin
        bus.ct_in     = rand128();
        bus.key_in    = rand128();
        bus.in_valid  = 1'($urandom_range(0, 1));
        bus.out_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      lat++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic releaseResult(input bit holdValid);
    bus.out_ready = 1'b1;
    if (holdValid) begin
      bus.in_valid = 1'b1;
      bus.ct_in    = CT_C;
      bus.key_in   = KEY_C;
    end
    @(negedge clk);
    checkOutput("out_valid_after_release", 128'(bus.out_valid), 128'd0);
    checkOutput("in_ready_after_release", 128'(bus.in_ready), 128'd1);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
  endtask

  task automatic runVector(input vec_t v, input string tag);
    int lat;
    bit busyBad;
    int expLat;
    expLat = expLatency(v.key);
    startJob(v.key, v.ct);
    applyStimulus(v.toggle, lat, busyBad);
    noteJob(v.key);
    checkOutput({tag, "_pt"}, bus.pt_out, v.pt);
    checkOutput({tag, "_latency"}, 128'(lat), 128'(expLat));
    checkOutput({tag, "_in_ready_busy"}, 128'(busyBad), 128'd0);
    releaseResult(1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec_t vecs[4];
    vec_t rv;
    int lat;
    bit busyBad;
    bit bpBad;
    logic [127:0] prevKey;

    buildTables();
    cacheValid    = 1'b0;
    cacheKey      = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.ct_in     = '0;
    bus.key_in    = '0;
    rst_n         = 1'b0;

    @(negedge clk);
    checkOutput("reset_in_ready", 128'(bus.in_ready), 128'd1);
    checkOutput("reset_out_valid", 128'(bus.out_valid), 128'd0);
    checkOutput("reset_pt_out", bus.pt_out, 128'd0);
    rst_n = 1'b1;

    vecs[0] = '{KEY_B, CT_B, PT_B, 1'b0};
    vecs[1] = '{KEY_C, CT_C, PT_C, 1'b0};
    vecs[2] = '{KEY_C, CT_C, PT_C, 1'b0};
    vecs[3] = '{KEY_B, CT_B, PT_B, 1'b1};
    for (int i = 0; i < 4; i++) begin
      runVector(vecs[i], $sformatf("kat%0d", i));
    end

    // Backpressure: result held for 7 cycles while the consumer stalls.
    startJob(KEY_C, CT_C);
    applyStimulus(1'b0, lat, busyBad);
    noteJob(KEY_C);
    checkOutput("bp_latency", 128'(lat), 128'(expLatency(128'd0) == 10 ? 20 : 20));
    bpBad = 1'b0;
    for (int c = 0; c < 7; c++) begin
      if (bus.pt_out !== PT_C || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) bpBad = 1'b1;
      @(negedge clk);
    end
    checkOutput("bp_hold_stable", 128'(bpBad), 128'd0);
    checkOutput("bp_pt", bus.pt_out, PT_C);
    releaseResult(1'b1);

    // Reset at cycle 12 of a job aborts it immediately.
    startJob(KEY_C, CT_C);
    repeat (12) @(negedge clk);
    rst_n      = 1'b0;
    cacheValid = 1'b0;
    #1;
    checkOutput("midreset_out_valid", 128'(bus.out_valid), 128'd0);
    checkOutput("midreset_pt_out", bus.pt_out, 128'd0);
    checkOutput("midreset_in_ready", 128'(bus.in_ready), 128'd1);
    @(negedge clk);
    rst_n = 1'b1;
    runVector(vecs[1], "after_reset");

    // Randomized jobs with inputs churned while busy; odd jobs reuse the key.
    prevKey = KEY_C;
    for (int n = 0; n < 6; n++) begin
      rv.key    = (n % 2 == 1) ? prevKey : rand128();
      rv.ct     = rand128();
      rv.pt     = refDecrypt(rv.key, rv.ct);
      rv.toggle = 1'b1;
      prevKey   = rv.key;
      runVector(rv, $sformatf("rand%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
